// File: rtl/filter_seq_ctrl.sv
// Master sequencer for the 3x3 image filter: header load, 3x3 window reads, one write per pixel.
// Optional stall watchdog enabled by defining FILTER_SEQ_WDOG_EN.
module filter_seq_ctrl #(
  parameter int HDR_BYTES = 12,
  parameter int ROW_BYTES = 3
`ifdef FILTER_SEQ_WDOG_EN
  , parameter int WDOG_CYC = 1023
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       go,
  input  logic       idle_out,
  input  logic       user_data_available,
  input  logic       user_buffer_full,
  input  logic       image_done,
  output logic [2:0] address_select,
  output logic       rdwr_cntl,
  output logic       n_action,
  output logic       user_read_buffer,
  output logic       user_write_buffer,
  output logic       load_size,
  output logic       buffer_load,
  output logic       rw_load_ctrl,
  output logic       data_select,
  output logic       count_enable,
  output logic       flag_clear,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_REQ, S_HDR_RD, S_ROW_REQ, S_PIX_RD, S_CALC,
    S_WR_REQ, S_WR_PUSH, S_WR_WAIT, S_STEP, S_DONE, S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [2:0] addr_q, addr_d;
  logic       step_chk_q, step_chk_d;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      row_idx_q  <= '0;
      addr_q     <= '0;
      step_chk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      row_idx_q  <= row_idx_d;
      addr_q     <= addr_d;
      step_chk_q <= step_chk_d;
    end
  end

`ifdef FILTER_SEQ_WDOG_EN
  logic [9:0] wdog_q, wdog_d;
  logic       stall;

  // Any cycle spent waiting on the memory master or a FIFO counts as a stall.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_HDR_REQ, S_ROW_REQ, S_WR_REQ, S_WR_WAIT: stall = !idle_out;
      S_HDR_RD, S_PIX_RD:                        stall = !user_data_available;
      S_WR_PUSH:                                 stall = user_buffer_full;
      default:                                   stall = 1'b0;
    endcase
    wdog_d = stall ? wdog_q + 10'd1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`endif

  always_comb begin
    state_d           = state_q;
    byte_cnt_d        = byte_cnt_q;
    row_idx_d         = row_idx_q;
    addr_d            = addr_q;
    step_chk_d        = 1'b0;
    rdwr_cntl         = 1'b0;
    n_action          = 1'b1;
    user_read_buffer  = 1'b0;
    user_write_buffer = 1'b0;
    load_size         = 1'b0;
    buffer_load       = 1'b0;
    rw_load_ctrl      = 1'b0;
    data_select       = 1'b0;
    count_enable      = 1'b0;
    flag_clear        = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    err               = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          flag_clear = 1'b1;
          state_d    = S_HDR_REQ;
        end
      end
      S_HDR_REQ: if (idle_out) begin
        n_action   = 1'b0;
        rdwr_cntl  = 1'b1;
        addr_d     = 3'd0;
        byte_cnt_d = '0;
        state_d    = S_HDR_RD;
      end
      S_HDR_RD: if (user_data_available) begin
        user_read_buffer = 1'b1;
        load_size        = 1'b1;
        byte_cnt_d       = byte_cnt_q + 4'd1;
        if (byte_cnt_q == 4'(HDR_BYTES - 1)) begin
          byte_cnt_d = '0;
          row_idx_d  = '0;
          state_d    = S_ROW_REQ;
        end
      end
      S_ROW_REQ: if (idle_out) begin
        n_action   = 1'b0;
        rdwr_cntl  = 1'b1;
        addr_d     = 3'd1 + {1'b0, row_idx_q};
        byte_cnt_d = '0;
        state_d    = S_PIX_RD;
      end
      S_PIX_RD: if (user_data_available) begin
        user_read_buffer = 1'b1;
        buffer_load      = 1'b1;
        byte_cnt_d       = byte_cnt_q + 4'd1;
        if (byte_cnt_q == 4'(ROW_BYTES - 1)) begin
          byte_cnt_d = '0;
          if (row_idx_q < 2'd2) begin
            row_idx_d = row_idx_q + 2'd1;
            state_d   = S_ROW_REQ;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rw_load_ctrl = 1'b1;
        data_select  = 1'b1;
        state_d      = S_WR_REQ;
      end
      // Keep the filtered pixel on data_out until it is pushed.
      S_WR_REQ: begin
        data_select = 1'b1;
        if (idle_out) begin
          n_action = 1'b0;
          addr_d   = 3'd4;
          state_d  = S_WR_PUSH;
        end
      end
      S_WR_PUSH: begin
        data_select = 1'b1;
        if (!user_buffer_full) begin
          user_write_buffer = 1'b1;
          state_d           = S_WR_WAIT;
        end
      end
      S_WR_WAIT: if (idle_out) state_d = S_STEP;
      // First cycle steps the counters; image_done is valid on the second.
      S_STEP: begin
        if (!step_chk_q) begin
          count_enable = 1'b1;
          step_chk_d   = 1'b1;
        end else if (image_done) begin
          state_d = S_DONE;
        end else begin
          row_idx_d = '0;
          state_d   = S_ROW_REQ;
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy = 1'b0;
`ifdef FILTER_SEQ_WDOG_EN
        err  = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FILTER_SEQ_WDOG_EN
    if (stall && wdog_q == 10'(WDOG_CYC - 1)) state_d = S_ERR;
`endif

    address_select = addr_d;

    // Reset dominates every output, including a go seen during reset.
    if (!n_rst) begin
      address_select    = 3'd0;
      rdwr_cntl         = 1'b0;
      n_action          = 1'b1;
      user_read_buffer  = 1'b0;
      user_write_buffer = 1'b0;
      load_size         = 1'b0;
      buffer_load       = 1'b0;
      rw_load_ctrl      = 1'b0;
      data_select       = 1'b0;
      count_enable      = 1'b0;
      flag_clear        = 1'b0;
      busy              = 1'b0;
      done              = 1'b0;
      err               = 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed bench for filter_seq_ctrl; watchdog steps run when FILTER_SEQ_WDOG_EN is defined.
module tb_filter_seq_ctrl;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       go = 1'b0;
  logic       idle_out = 1'b1;
  logic       uda = 1'b1;
  logic       ubf = 1'b0;
  logic       image_done = 1'b0;
  logic [2:0] address_select;
  logic       rdwr_cntl, n_action, user_read_buffer, user_write_buffer, load_size;
  logic       buffer_load, rw_load_ctrl, data_select, count_enable, flag_clear;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;
  int npix = 1;
  int px_cnt = 0;
  int n_ld = 0, n_bl = 0, n_rd = 0, n_wr = 0, n_nact = 0, n_ce = 0, n_done = 0, n_wr_full = 0;
  logic [14:0] addr_hist = '0;
  logic [4:0]  rw_hist = '0;
  int b_ld, b_bl, b_rd, b_wr, b_nact, b_ce, b_done;
  int k;

  filter_seq_ctrl dut (
    .clk(clk), .n_rst(n_rst), .go(go), .idle_out(idle_out),
    .user_data_available(uda), .user_buffer_full(ubf), .image_done(image_done),
    .address_select(address_select), .rdwr_cntl(rdwr_cntl), .n_action(n_action),
    .user_read_buffer(user_read_buffer), .user_write_buffer(user_write_buffer),
    .load_size(load_size), .buffer_load(buffer_load), .rw_load_ctrl(rw_load_ctrl),
    .data_select(data_select), .count_enable(count_enable), .flag_clear(flag_clear),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Pixel counter model: image_done rises with the step of the last pixel.
  always @(posedge clk) begin
    if (flag_clear) begin
      px_cnt     <= 0;
      image_done <= 1'b0;
    end else if (count_enable) begin
      px_cnt     <= px_cnt + 1;
      image_done <= (px_cnt + 1 >= npix);
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      n_ld   <= n_ld + (load_size ? 1 : 0);
      n_bl   <= n_bl + (buffer_load ? 1 : 0);
      n_rd   <= n_rd + (user_read_buffer ? 1 : 0);
      n_wr   <= n_wr + (user_write_buffer ? 1 : 0);
      n_ce   <= n_ce + (count_enable ? 1 : 0);
      n_done <= n_done + (done ? 1 : 0);
      if (!n_action) begin
        n_nact    <= n_nact + 1;
        addr_hist <= {addr_hist[11:0], address_select};
        rw_hist   <= {rw_hist[3:0], rdwr_cntl};
      end
      if (user_write_buffer && ubf) n_wr_full <= n_wr_full + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_ld = n_ld; b_bl = n_bl; b_rd = n_rd; b_wr = n_wr;
    b_nact = n_nact; b_ce = n_ce; b_done = n_done;
  endtask

  // Pulses go for one cycle; returns one cycle into the job (HDR_REQ).
  task automatic start_job(input int np);
    npix = np;
    tick();
    go = 1'b1;
    @(negedge clk);
    chk("flag_clear_on_go", flag_clear, 1);
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int kk);
    kk = k0;
    while (kk < 3000) begin
      @(negedge clk);
      if (done) break;
      kk++;
    end
    if (kk >= 3000) chk("done_timeout", 0, 1);
  endtask

  initial begin
    // Reset with go asserted: reset wins.
    go = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_n_action", n_action, 1);
    chk("rst_flag_clear", flag_clear, 0);
    chk("rst_outputs", {address_select, rdwr_cntl, user_read_buffer, user_write_buffer,
                        load_size, buffer_load, rw_load_ctrl, data_select, count_enable,
                        busy, done, err}, 0);
    go = 1'b0;
    tick();
    n_rst = 1'b1;

    // 1-pixel image, no stalls.
    snap();
    start_job(1);
    wait_done(1, k);
    chk("p1_go_to_done", k, 32);
    chk("p1_busy_in_done", busy, 0);
    tick();
    chk("p1_load_size", n_ld - b_ld, 12);
    chk("p1_buffer_load", n_bl - b_bl, 9);
    chk("p1_reads", n_rd - b_rd, 21);
    chk("p1_n_action", n_nact - b_nact, 5);
    chk("p1_writes", n_wr - b_wr, 1);
    chk("p1_count_enable", n_ce - b_ce, 1);
    chk("p1_done_pulses", n_done - b_done, 1);
    chk("p1_addr_seq", addr_hist, 15'b000_001_010_011_100);
    chk("p1_rdwr_seq", rw_hist, 5'b11110);

    // 2-pixel image; go during DONE must be ignored.
    snap();
    start_job(2);
    wait_done(1, k);
    chk("p2_go_to_done", k, 50);
    go = 1'b1;
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("p2_go_in_done_ignored", busy, 0);
    chk("p2_buffer_load", n_bl - b_bl, 18);
    chk("p2_writes", n_wr - b_wr, 2);
    chk("p2_count_enable", n_ce - b_ce, 2);
    chk("p2_n_action", n_nact - b_nact, 9);
    chk("p2_addr_seq", addr_hist, 15'b100_001_010_011_100);

    // Read stall mid-PIX_RD.
    snap();
    start_job(1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_bl - b_bl >= 4) break;
    end
    chk("rs_reached_mid_row", n_bl - b_bl, 4);
    uda = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rs_no_pop_while_empty", user_read_buffer, 0);
    end
    tick();
    uda = 1'b1;
    wait_done(0, k);
    tick();
    chk("rs_buffer_load", n_bl - b_bl, 9);
    chk("rs_reads", n_rd - b_rd, 21);
    chk("rs_load_size", n_ld - b_ld, 12);

    // Write backpressure.
    snap();
    ubf = 1'b1;
    start_job(1);
    for (int i = 0; i < 48; i++) tick();
    @(negedge clk);
    chk("bp_no_write_while_full", n_wr - b_wr, 0);
    chk("bp_busy_stalled", busy, 1);
    chk("bp_data_select_held", data_select, 1);
    tick();
    ubf = 1'b0;
    wait_done(0, k);
    tick();
    chk("bp_writes", n_wr - b_wr, 1);
    chk("bp_write_while_full", n_wr_full, 0);

    // Mid-job reset in PIX_RD, then restart.
    snap();
    start_job(1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_bl - b_bl >= 2) break;
    end
    n_rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mr_busy_in_reset", busy, 0);
    chk("mr_n_action_in_reset", n_action, 1);
    tick();
    n_rst = 1'b1;
    snap();
    start_job(1);
    @(negedge clk);
    chk("mr_hdr_req_n_action", n_action, 0);
    chk("mr_hdr_req_addr", address_select, 0);
    chk("mr_hdr_req_rdwr", rdwr_cntl, 1);
    wait_done(2, k);
    chk("mr_go_to_done", k, 32);
    tick();
    chk("mr_buffer_load", n_bl - b_bl, 9);

`ifdef FILTER_SEQ_WDOG_EN
    // Watchdog: idle_out held low in ROW_REQ.
    snap();
    start_job(1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_ld - b_ld >= 12) break;
    end
    idle_out = 1'b0;
    k = 1;
    while (k < 1200) begin
      @(negedge clk);
      if (err) break;
      k++;
    end
    chk("wd_cycles_to_err", k, 1024);
    chk("wd_busy", busy, 0);
    chk("wd_n_action", n_action, 1);
    tick();
    go = 1'b1;
    @(negedge clk);
    chk("wd_go_ignored_flag_clear", flag_clear, 0);
    tick();
    go = 1'b0;
    @(negedge clk);
    chk("wd_err_sticky", err, 1);
    chk("wd_busy_after_go", busy, 0);
    n_rst = 1'b0;
    tick();
    @(negedge clk);
    chk("wd_err_cleared_by_reset", err, 0);
    idle_out = 1'b1;
    tick();
    n_rst = 1'b1;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
